// File: rtl/wr_flag_conditioner.sv
// rtl/wr_flag_conditioner.sv - write-domain almost-full, wrap and overflow flag conditioner
//
// Purpose:
//   Conditions write-side FIFO status into user-facing flags:
//   - hysteretic almost-full (set at AF_SET, clear at AF_CLR), delayed by DELAY stages
//   - one-cycle rise/fall pulses on the delayed almost-full
//   - write-pointer wrap pulse plus a modulo wrap counter
//   - sticky overflow flag for writes attempted while full
//
// Ports:
//   clk_w          write clock
//   rst_w          asynchronous active-low reset
//   wr_en          write request this cycle
//   full           FIFO full flag
//   fill_lvl       write-side fill level, ADDR_W+1 bits
//   wr_ptr_msb     wrap bit of the binary write pointer
//   clr            synchronous clear of wrap_cnt and ovf_sticky
//   alm_full_dly   hysteretic almost-full after DELAY stages
//   alm_full_rise  one-cycle pulse on alm_full_dly 0->1
//   alm_full_fall  one-cycle pulse on alm_full_dly 1->0
//   wrap_pulse     one-cycle pulse per write-pointer wrap
//   wrap_cnt       wraps since reset/clr, modulo 2^WRAP_CNT_W
//   ovf_sticky     set on write attempt while full

module wr_flag_conditioner #(
    parameter int ADDR_W     = 4,
    parameter int DELAY      = 1,
    parameter int AF_SET     = 14,
    parameter int AF_CLR     = 12,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk_w,
    input  logic                  rst_w,
    input  logic                  wr_en,
    input  logic                  full,
    input  logic [ADDR_W:0]       fill_lvl,
    input  logic                  wr_ptr_msb,
    input  logic                  clr,
    output logic                  alm_full_dly,
    output logic                  alm_full_rise,
    output logic                  alm_full_fall,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic                  ovf_sticky
);

    localparam logic [ADDR_W:0] LP_SET   = (ADDR_W+1)'(AF_SET);
    localparam logic [ADDR_W:0] LP_CLR   = (ADDR_W+1)'(AF_CLR);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(1 << ADDR_W);

    typedef enum logic {
        AF_ST_CLEAR = 1'b0,
        AF_ST_SET   = 1'b1
    } af_state_t;

    af_state_t r_af_q;
    af_state_t w_af_next;

    logic                  w_set_cond;
    logic                  w_clr_cond;
    logic [DELAY-1:0]      w_stage;
    logic                  r_alm_prev;
    logic                  r_msb_q;
    logic                  r_wrap_pulse;
    logic                  w_wrap;
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;
    logic                  r_ovf;
    logic                  w_ovf_set;

    // An out-of-range fill level is treated as almost-full so a corrupted
    // level can never mask a real near-full condition.
    assign w_set_cond = (fill_lvl >= LP_SET) || (fill_lvl > LP_DEPTH);
    assign w_clr_cond = (fill_lvl <= LP_CLR) && !(fill_lvl > LP_DEPTH);

    // Hysteresis FSM: state register
    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            r_af_q <= AF_ST_CLEAR;
        end else begin
            r_af_q <= w_af_next;
        end
    end

    // Hysteresis FSM: next state
    always_comb begin
        w_af_next = r_af_q;
        case (r_af_q)
            AF_ST_CLEAR: if (w_set_cond) w_af_next = AF_ST_SET;
            AF_ST_SET:   if (w_clr_cond) w_af_next = AF_ST_CLEAR;
            default:     w_af_next = AF_ST_CLEAR;
        endcase
    end

    // The FSM register is the first delay stage; DELAY-1 more follow it.
    assign w_stage[0] = (r_af_q == AF_ST_SET);

    for (genvar gi = 1; gi < DELAY; gi++) begin : g_dly
        logic r_stage;
        always_ff @(posedge clk_w or negedge rst_w) begin
            if (!rst_w) begin
                r_stage <= 1'b0;
            end else begin
                r_stage <= w_stage[gi-1];
            end
        end
        assign w_stage[gi] = r_stage;
    end

    assign alm_full_dly = w_stage[DELAY-1];

    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            r_alm_prev <= 1'b0;
        end else begin
            r_alm_prev <= alm_full_dly;
        end
    end

    assign alm_full_rise = alm_full_dly & ~r_alm_prev;
    assign alm_full_fall = ~alm_full_dly & r_alm_prev;

    // Any change of the pointer wrap bit is one wrap, in either direction.
    assign w_wrap = wr_ptr_msb ^ r_msb_q;

    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            r_msb_q      <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_msb_q      <= wr_ptr_msb;
            r_wrap_pulse <= w_wrap;
        end
    end

    // clr wins over a coincident wrap; that wrap is dropped from the count.
    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            r_wrap_cnt <= '0;
        end else if (clr) begin
            r_wrap_cnt <= '0;
        end else if (w_wrap) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

    assign w_ovf_set = wr_en & full;

    // A new overflow on the same edge as clr keeps the flag set.
    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign wrap_pulse = r_wrap_pulse;
    assign wrap_cnt   = r_wrap_cnt;
    assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_wr_flag_conditioner.sv
// tb/tb_wr_flag_conditioner.sv - self-checking bench for wr_flag_conditioner
module tb_wr_flag_conditioner;

    logic       clk_w = 1'b0;
    logic       rst_w;
    logic       wr_en;
    logic       full;
    logic [4:0] fill_lvl;
    logic       wr_ptr_msb;
    logic       clr;

    logic       a_alm, a_rise, a_fall, a_wrap, a_ovf;
    logic [7:0] a_cnt;
    logic       b_alm, b_rise, b_fall, b_wrap, b_ovf;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_w = ~clk_w;

    wr_flag_conditioner #(.ADDR_W(4), .DELAY(1), .AF_SET(14), .AF_CLR(12), .WRAP_CNT_W(8)) dut_a (
        .clk_w(clk_w), .rst_w(rst_w), .wr_en(wr_en), .full(full), .fill_lvl(fill_lvl),
        .wr_ptr_msb(wr_ptr_msb), .clr(clr),
        .alm_full_dly(a_alm), .alm_full_rise(a_rise), .alm_full_fall(a_fall),
        .wrap_pulse(a_wrap), .wrap_cnt(a_cnt), .ovf_sticky(a_ovf)
    );

    wr_flag_conditioner #(.ADDR_W(4), .DELAY(3), .AF_SET(14), .AF_CLR(12), .WRAP_CNT_W(2)) dut_b (
        .clk_w(clk_w), .rst_w(rst_w), .wr_en(wr_en), .full(full), .fill_lvl(fill_lvl),
        .wr_ptr_msb(wr_ptr_msb), .clr(clr),
        .alm_full_dly(b_alm), .alm_full_rise(b_rise), .alm_full_fall(b_fall),
        .wrap_pulse(b_wrap), .wrap_cnt(b_cnt), .ovf_sticky(b_ovf)
    );

    // Reference model: almost-full level history (newest first), wrap and overflow bookkeeping.
    int m_af;
    int hist[$];
    int m_prev_msb;
    int m_wrap;
    int m_cnt_a;
    int m_cnt_b;
    int m_ovf;

    function automatic int exp_alm(int d);
        return (hist.size() >= d) ? hist[d-1] : 0;
    endfunction

    function automatic int exp_prev(int d);
        return (hist.size() > d) ? hist[d] : 0;
    endfunction

    task automatic model_reset();
        m_af = 0;
        hist.delete();
        m_prev_msb = 0;
        m_wrap = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_ovf = 0;
    endtask

    task automatic model_update();
        int lvl;
        if (!rst_w) begin
            model_reset();
            return;
        end
        lvl = int'(fill_lvl);
        if (lvl >= 14 || lvl > 16) m_af = 1;
        else if (lvl <= 12) m_af = 0;
        hist.push_front(m_af);
        if (hist.size() > 8) void'(hist.pop_back());
        m_wrap = (int'(wr_ptr_msb) != m_prev_msb) ? 1 : 0;
        m_prev_msb = int'(wr_ptr_msb);
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            m_cnt_a = (m_cnt_a + m_wrap) % 256;
            m_cnt_b = (m_cnt_b + m_wrap) % 4;
        end
        if (wr_en && full) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int ea, eb;
        ea = exp_alm(1);
        eb = exp_alm(3);
        chk("a_alm",  32'(a_alm),  32'(ea));
        chk("a_rise", 32'(a_rise), 32'(ea & ~exp_prev(1) & 1));
        chk("a_fall", 32'(a_fall), 32'(~ea & exp_prev(1) & 1));
        chk("a_wrap", 32'(a_wrap), 32'(m_wrap));
        chk("a_cnt",  32'(a_cnt),  32'(m_cnt_a));
        chk("a_ovf",  32'(a_ovf),  32'(m_ovf));
        chk("b_alm",  32'(b_alm),  32'(eb));
        chk("b_rise", 32'(b_rise), 32'(eb & ~exp_prev(3) & 1));
        chk("b_fall", 32'(b_fall), 32'(~eb & exp_prev(3) & 1));
        chk("b_wrap", 32'(b_wrap), 32'(m_wrap));
        chk("b_cnt",  32'(b_cnt),  32'(m_cnt_b));
        chk("b_ovf",  32'(b_ovf),  32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk_w);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        rst_w      = 1'b0;
        wr_en      = 1'b0;
        full       = 1'b0;
        fill_lvl   = 5'd16;
        wr_ptr_msb = 1'b1;
        clr        = 1'b0;

        // Reset with aggressive inputs held: outputs stay 0.
        step();
        step();
        chk("rst_alm_a", 32'(a_alm), 32'd0);
        chk("rst_wrap_a", 32'(a_wrap), 32'd0);

        // Release: first sampling edge raises DELAY=1 flag and flags a wrap.
        rst_w = 1'b1;
        step();
        chk("rel_alm_a", 32'(a_alm), 32'd1);
        chk("rel_rise_a", 32'(a_rise), 32'd1);
        chk("rel_alm_b1", 32'(b_alm), 32'd0);
        step();
        step();
        chk("rel_alm_b3", 32'(b_alm), 32'd1);
        chk("rel_rise_b3", 32'(b_rise), 32'd1);
        step();
        chk("rel_rise_a_once", 32'(a_rise), 32'd0);

        // Hysteresis sequence from empty.
        fill_lvl = 5'd0;
        for (int i = 0; i < 4; i++) step();
        fill_lvl = 5'd13; step();
        chk("hys13_alm", 32'(a_alm), 32'd0);
        fill_lvl = 5'd14; step();
        chk("hys14_alm", 32'(a_alm), 32'd1);
        chk("hys14_rise", 32'(a_rise), 32'd1);
        fill_lvl = 5'd13; step();
        chk("hys13b_alm", 32'(a_alm), 32'd1);
        fill_lvl = 5'd12; step();
        chk("hys12_alm", 32'(a_alm), 32'd0);
        chk("hys12_fall", 32'(a_fall), 32'd1);
        fill_lvl = 5'd13; step();
        chk("hys13c_alm", 32'(a_alm), 32'd0);

        // DELAY=3 step 0 -> 15 -> 0.
        fill_lvl = 5'd0;
        for (int i = 0; i < 4; i++) step();
        fill_lvl = 5'd15;
        step(); step();
        chk("d3_rise_early", 32'(b_alm), 32'd0);
        step();
        chk("d3_rise_at3", 32'(b_alm), 32'd1);
        chk("d3_rise_pulse", 32'(b_rise), 32'd1);
        for (int i = 0; i < 3; i++) step();
        fill_lvl = 5'd0;
        step(); step();
        chk("d3_fall_early", 32'(b_alm), 32'd1);
        step();
        chk("d3_fall_at3", 32'(b_alm), 32'd0);
        chk("d3_fall_pulse", 32'(b_fall), 32'd1);

        // Wrap counting: four toggles, two of them adjacent.
        clr = 1'b1; step(); clr = 1'b0;
        wr_ptr_msb = ~wr_ptr_msb; step();
        step(); step();
        wr_ptr_msb = ~wr_ptr_msb; step();
        wr_ptr_msb = ~wr_ptr_msb; step();
        chk("wrap_adj_pulse", 32'(a_wrap), 32'd1);
        step();
        wr_ptr_msb = ~wr_ptr_msb; step();
        chk("wrap_cnt4_a", 32'(a_cnt), 32'd4);
        chk("wrap_cnt4_b", 32'(b_cnt), 32'd0);
        wr_ptr_msb = ~wr_ptr_msb; step();
        chk("wrap_cnt5_b", 32'(b_cnt), 32'd1);

        // clr priority.
        wr_ptr_msb = ~wr_ptr_msb; clr = 1'b1; step();
        chk("clr_wrap_pulse", 32'(a_wrap), 32'd1);
        chk("clr_wrap_cnt", 32'(a_cnt), 32'd0);
        wr_en = 1'b1; full = 1'b1; clr = 1'b1; step();
        chk("ovf_set_wins", 32'(a_ovf), 32'd1);
        wr_en = 1'b0; full = 1'b0; clr = 1'b1; step();
        chk("ovf_cleared", 32'(a_ovf), 32'd0);
        clr = 1'b0;

        // Randomized operation.
        for (int i = 0; i < 400; i++) begin
            fill_lvl = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            if ($urandom_range(0, 2) == 0) wr_ptr_msb = ~wr_ptr_msb;
            wr_en = 1'($urandom);
            full  = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 11) == 0);
            step();
        end

        // Async reset mid-cycle with alm_full_dly=1 and wrap_cnt=7.
        wr_en = 1'b0; full = 1'b0; fill_lvl = 5'd16;
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_ptr_msb = ~wr_ptr_msb;
            step();
        end
        step();
        chk("pre_arst_alm", 32'(a_alm), 32'd1);
        chk("pre_arst_cnt", 32'(a_cnt), 32'd7);
        #2;
        rst_w = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        rst_w = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wr_flag_conditioner.md
Name: wr_flag_conditioner

Overview:
Write-clock-domain flag conditioner for the asynchronous FIFO. It generalises the single-stage almost-full delay into a hysteretic almost-full generator with a parametrised delay line and edge pulses. It also provides write-pointer wrap-around detection with a wrap counter and a sticky write-overflow flag. It sits between the write-side pointer/fill logic and the write-side user interface.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2^ADDR_W
DELAY, 1, register stages from fill_lvl sample to alm_full_dly; legal 1..8
AF_SET, 14, fill level at or above which almost-full asserts
AF_CLR, 12, fill level at or below which almost-full deasserts; AF_CLR < AF_SET <= 2^ADDR_W
WRAP_CNT_W, 8, width of wrap counter

Ports:
clk_w  in  1  write clock
rst_w  in  1  asynchronous active-low reset
wr_en  in  1  write request this cycle
full  in  1  FIFO full flag (write domain)
fill_lvl  in  ADDR_W+1  current write-side fill level
wr_ptr_msb  in  1  MSB (wrap bit) of binary write pointer
clr  in  1  synchronous clear of wrap_cnt and ovf_sticky
alm_full_dly  out  1  hysteretic almost-full after DELAY stages
alm_full_rise  out  1  one-cycle pulse, alm_full_dly 0->1
alm_full_fall  out  1  one-cycle pulse, alm_full_dly 1->0
wrap_pulse  out  1  one-cycle pulse per write-pointer wrap
wrap_cnt  out  WRAP_CNT_W  number of wraps since reset/clr, modulo 2^WRAP_CNT_W
ovf_sticky  out  1  set on write attempt while full

Behaviour:
- Reset (rst_w low, async, any time incl. mid-operation): all state and outputs = 0. This includes af state, every delay stage, the msb sample register, the pulses, wrap_cnt and ovf_sticky.
- Hysteresis FSM, stage 1 register af_q, two states:
  - CLEAR -> SET when fill_lvl >= AF_SET.
  - SET -> CLEAR when fill_lvl <= AF_CLR.
  - Otherwise the state holds.
  - fill_lvl > 2^ADDR_W (illegal) is treated as >= AF_SET.
- Delay line: af_q feeds DELAY-1 further registers; alm_full_dly = last stage. Latency from the fill_lvl edge to alm_full_dly = DELAY cycles. With DELAY=1, alm_full_dly = af_q.
- Edge pulses: one extra register holds the previous alm_full_dly.
  - alm_full_rise = alm_full_dly & ~prev.
  - alm_full_fall = ~alm_full_dly & prev.
  - Each pulse is high exactly in the first cycle of the new level. Both are never high together.
- Wrap detection: msb_q registers wr_ptr_msb (reset 0). wrap_pulse is registered and high for one cycle following any clock edge where wr_ptr_msb != msb_q. Both 0->1 and 1->0 count as wraps. Consecutive toggles give consecutive pulses.
- wrap_cnt: increments by 1 in the same cycle wrap_pulse is asserted; wraps modulo 2^WRAP_CNT_W (all-ones -> 0). If clr is high on the edge, wrap_cnt <= 0; clr has priority over a simultaneous increment, and that wrap is not counted. wrap_pulse itself is unaffected by clr.
- ovf_sticky: set on an edge where wr_en & full. It stays set until an edge with clr & ~(wr_en & full). When set and clr coincide, set wins.
- No combinational path from inputs to outputs; all outputs come directly from registers or from an AND of registers.

Test Plan:
- Reset: drive fill_lvl=16 and wr_ptr_msb=1 during reset, then release -> all outputs 0 during reset. After release, alm_full_dly rises DELAY cycles after the first sampling edge, with alm_full_rise high for 1 cycle.
- Hysteresis (ADDR_W=4, AF_SET=14, AF_CLR=12, DELAY=1): fill sequence 13,14,13,12,13 -> alm_full_dly 0,1,1,0,0 (shifted 1 cycle); rise at 14, fall at 12.
- DELAY=3: step fill_lvl 0->15 -> alm_full_dly rises exactly 3 cycles later. Hold 15 then drop to 0 -> falls 3 cycles later; one rise and one fall pulse.
- Wrap: toggle wr_ptr_msb 4 times at arbitrary spacing (incl. two adjacent cycles) -> 4 wrap_pulse cycles, wrap_cnt=4. With WRAP_CNT_W=2, a 5th toggle -> wrap_cnt=1.
- Clear priority: clr together with a wrap -> wrap_pulse=1, wrap_cnt=0. wr_en=1, full=1 with clr=1 -> ovf_sticky=1. clr alone next cycle -> ovf_sticky=0.
- Async reset mid-run: assert rst_w between clock edges with alm_full_dly=1 and wrap_cnt=7 -> all outputs 0 immediately, without waiting for a clk_w edge.
